// File: rtl/lc3b_regfile_sb.sv
// LC-3b general register file: eight registers, one write-back port,
// two bypassed read ports and a per-register pending-write scoreboard.
// Decode reserves destinations (issue), write-back retires them; readers
// get write-through data plus a busy flag for hazard stalls.
module lc3b_regfile_sb #(
    parameter int width     = 16,
    parameter int pend_bits = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [2:0]       issue_dest,
    output logic             issue_ok,
    input  logic             wb_valid,
    input  logic [2:0]       wb_dest,
    input  logic [width-1:0] wb_data,
    input  logic [2:0]       src_a,
    input  logic [2:0]       src_b,
    output logic [width-1:0] reada,
    output logic [width-1:0] readb,
    output logic             busy_a,
    output logic             busy_b,
    output logic [7:0]       busy_mask,
    output logic             underflow_err
);

    localparam logic [pend_bits-1:0] cnt_max = '1;
    localparam logic [pend_bits-1:0] cnt_one = pend_bits'(1);

    logic [width-1:0]     regs [8];
    logic [pend_bits-1:0] cnt  [8];
    logic [7:0]           inc;
    logic [7:0]           dec;

    // Reservation is granted below saturation, or at saturation when the
    // same register retires a write this cycle (net count unchanged).
    always_comb begin
        issue_ok = issue_valid &&
                   ((cnt[issue_dest] != cnt_max) ||
                    (wb_valid && (wb_dest == issue_dest)));
    end

    // One-hot issue/retire decode per register.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < 8; i++) begin
            inc[i] = issue_ok && (issue_dest == 3'(i));
            dec[i] = wb_valid && (wb_dest == 3'(i));
        end
    end

    // Read ports with same-cycle write-back bypass.
    always_comb begin
        reada = (wb_valid && (wb_dest == src_a)) ? wb_data : regs[src_a];
        readb = (wb_valid && (wb_dest == src_b)) ? wb_data : regs[src_b];
    end

    // Busy flags: the final outstanding write retiring this cycle clears
    // busy early; a same-cycle issue only shows from the next cycle.
    always_comb begin
        busy_a = (cnt[src_a] != '0) &&
                 !(wb_valid && (wb_dest == src_a) && (cnt[src_a] == cnt_one));
        busy_b = (cnt[src_b] != '0) &&
                 !(wb_valid && (wb_dest == src_b) && (cnt[src_b] == cnt_one));
    end

    // Raw scoreboard view straight from the counters, no bypass.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < 8; i++) begin
            busy_mask[i] = (cnt[i] != '0);
        end
    end

    // Register storage, pending counters and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            underflow_err <= 1'b0;
        end else begin
            if (wb_valid) begin
                regs[wb_dest] <= wb_data;
            end
            for (int i = 0; i < 8; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + cnt_one;
                end else if (dec[i] && !inc[i]) begin
                    if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - cnt_one;
                    end else begin
                        underflow_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lc3b_regfile_sb.sv
// Bench for lc3b_regfile_sb: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural register/scoreboard model.
module tb_lc3b_regfile_sb;

    localparam int width     = 16;
    localparam int pend_bits = 2;
    localparam int max_cnt   = (1 << pend_bits) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic [2:0]       issue_dest;
    logic             issue_ok;
    logic             wb_valid;
    logic [2:0]       wb_dest;
    logic [width-1:0] wb_data;
    logic [2:0]       src_a;
    logic [2:0]       src_b;
    logic [width-1:0] reada;
    logic [width-1:0] readb;
    logic             busy_a;
    logic             busy_b;
    logic [7:0]       busy_mask;
    logic             underflow_err;

    lc3b_regfile_sb #(.width(width), .pend_bits(pend_bits)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ok(issue_ok),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .src_a(src_a), .src_b(src_b), .reada(reada), .readb(readb),
        .busy_a(busy_a), .busy_b(busy_b), .busy_mask(busy_mask),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [width-1:0] m_reg [8];
    int               m_cnt [8];
    bit               m_err;
    bit               m_known;

    int n_vec;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, clock it.
    task automatic step(input bit rst, input bit iv, input int id,
                        input bit wv, input int wd, input logic [width-1:0] wdat,
                        input int sa, input int sb);
        bit               e_ok;
        logic [width-1:0] e_ra, e_rb;
        bit               e_ba, e_bb;
        logic [7:0]       e_mask;
        @(negedge clk);
        reset       = rst;
        issue_valid = iv;
        issue_dest  = 3'(id);
        wb_valid    = wv;
        wb_dest     = 3'(wd);
        wb_data     = wdat;
        src_a       = 3'(sa);
        src_b       = 3'(sb);
        #1;
        if (m_known) begin
            e_ok = iv && ((m_cnt[id] < max_cnt) || (wv && wd == id));
            e_ra = (wv && wd == sa) ? wdat : m_reg[sa];
            e_rb = (wv && wd == sb) ? wdat : m_reg[sb];
            e_ba = (m_cnt[sa] != 0) && !(wv && wd == sa && m_cnt[sa] == 1);
            e_bb = (m_cnt[sb] != 0) && !(wv && wd == sb && m_cnt[sb] == 1);
            e_mask = '0;
            for (int i = 0; i < 8; i++) e_mask[i] = (m_cnt[i] != 0);
            chk("issue_ok", 32'(issue_ok), 32'(e_ok));
            chk("reada", 32'(reada), 32'(e_ra));
            chk("readb", 32'(readb), 32'(e_rb));
            chk("busy_a", 32'(busy_a), 32'(e_ba));
            chk("busy_b", 32'(busy_b), 32'(e_bb));
            chk("busy_mask", 32'(busy_mask), 32'(e_mask));
            chk("underflow_err", 32'(underflow_err), 32'(m_err));
        end else begin
            e_ok = 1'b0;
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i] = '0;
                m_cnt[i] = 0;
            end
            m_err   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (wv) m_reg[wd] = wdat;
            if (e_ok && !(wv && wd == id)) m_cnt[id] = m_cnt[id] + 1;
            if (wv && !(e_ok && wd == id)) begin
                if (m_cnt[wd] > 0) m_cnt[wd] = m_cnt[wd] - 1;
                else m_err = 1'b1;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        m_known = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        reset = 1'b1; issue_valid = 0; issue_dest = 0; wb_valid = 0;
        wb_dest = 0; wb_data = 0; src_a = 0; src_b = 0;

        // Reset, then read every register on both ports
        step(1, 0, 0, 0, 0, 16'h0, 0, 0);
        for (int r = 0; r < 8; r++) step(0, 0, 0, 0, 0, 16'h0, r, 7 - r);

        // Reserve R3, retire with bypass two cycles later
        step(0, 1, 3, 0, 0, 16'h0, 3, 0);
        step(0, 0, 0, 0, 0, 16'h0, 3, 3);
        step(0, 0, 0, 1, 3, 16'hBEEF, 3, 3);
        step(0, 0, 0, 0, 0, 16'h0, 3, 3);

        // Saturate R5, try past max, then at max with a same-cycle retire
        step(0, 1, 5, 0, 0, 16'h0, 5, 5);
        step(0, 1, 5, 0, 0, 16'h0, 5, 5);
        step(0, 1, 5, 0, 0, 16'h0, 5, 5);
        step(0, 1, 5, 0, 0, 16'h0, 5, 5);
        step(0, 1, 5, 1, 5, 16'h5555, 5, 5);
        step(0, 0, 0, 0, 0, 16'h0, 5, 5);

        // Issue and write-back R2 together while idle: no underflow
        step(0, 1, 2, 1, 2, 16'h1234, 2, 2);
        step(0, 0, 0, 0, 0, 16'h0, 2, 0);

        // Unreserved write-back to R7 sets the sticky error
        step(0, 0, 0, 1, 7, 16'h00FF, 7, 0);
        step(0, 0, 0, 0, 0, 16'h0, 7, 0);
        step(0, 1, 6, 0, 0, 16'h0, 6, 7);

        // Reservations in flight are wiped by reset; reset beats write-back
        step(0, 1, 1, 0, 0, 16'h0, 1, 4);
        step(1, 1, 4, 1, 1, 16'hAAAA, 1, 4);
        step(0, 0, 0, 0, 0, 16'h0, 1, 4);

        // Random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 79) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                 16'($urandom),
                 $urandom_range(0, 7), $urandom_range(0, 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
